pwm_deadtime: RTL and testbench

- Downstream stage of the PWM generator. Takes its single-ended `out` waveform and drives a complementary high-side/low-side gate pair.
- Inserts a programmable dead time between turning one switch off and the other on, so the two outputs never overlap.
- Includes a latched fault shutdown that forces both gates off until an explicit clear.
- Outputs feed the board-level gate drivers directly.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/sync_ff.sv | 26 ++
 rtl/pwm_deadtime.sv | 119 +++++++++++
 tb/tb_pwm_deadtime.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM dead-time stage.
package pwm_pkg;

  localparam int DT_WIDTH_DEF = 4;
  localparam int DEAD_MAX     = (2 ** DT_WIDTH_DEF) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_DEAD_TO_HI,
    ST_HIGH,
    ST_DEAD_TO_LO,
    ST_FAULT
  } dt_state_t;

  function automatic logic is_dead(input dt_state_t s);
    return (s == ST_DEAD_TO_HI) || (s == ST_DEAD_TO_LO);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchronizer with async active-low reset; output is the last stage.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_pipe;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign q = r_pipe[STAGES-1];

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time and latched fault shutdown.
//
// state         | meaning
// ST_IDLE       | disabled, both gates off
// ST_LOW        | low-side gate on
// ST_DEAD_TO_HI | both off, counting down before high side turns on
// ST_HIGH       | high-side gate on
// ST_DEAD_TO_LO | both off, counting down before low side turns on
// ST_FAULT      | latched shutdown, both off until faultClear
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH    = DT_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                enable,
  input  logic                pwmIn,
  input  logic [DT_WIDTH-1:0] deadTime,
  input  logic                fault,
  input  logic                faultClear,
  output logic                outHigh,
  output logic                outLow,
  output logic                faultLatched,
  output logic                busy
);

  logic                w_pwm_q;
  logic                w_fault_q;
  dt_state_t           r_state;
  dt_state_t           w_next_state;
  logic [DT_WIDTH-1:0] r_dead_cnt;
  logic [DT_WIDTH-1:0] w_next_cnt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pwm (
    .clock  (clock),
    .resetN (resetN),
    .d      (pwmIn),
    .q      (w_pwm_q)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_fault (
    .clock  (clock),
    .resetN (resetN),
    .d      (fault),
    .q      (w_fault_q)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_dead_cnt;
    if (w_fault_q) begin
      w_next_state = ST_FAULT;
    end else if (r_state == ST_FAULT) begin
      // Latched: only an explicit clear releases it, enable alone does not.
      if (faultClear) w_next_state = ST_IDLE;
    end else if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = w_pwm_q ? ST_HIGH : ST_LOW;
        ST_LOW: begin
          if (w_pwm_q) begin
            if (deadTime == '0) begin
              w_next_state = ST_HIGH;
            end else begin
              w_next_state = ST_DEAD_TO_HI;
              w_next_cnt   = deadTime;
            end
          end
        end
        ST_DEAD_TO_HI: begin
          if (!w_pwm_q)                          w_next_state = ST_LOW;
          else if (r_dead_cnt == DT_WIDTH'(1))   w_next_state = ST_HIGH;
          else                                   w_next_cnt   = r_dead_cnt - DT_WIDTH'(1);
        end
        ST_HIGH: begin
          if (!w_pwm_q) begin
            if (deadTime == '0) begin
              w_next_state = ST_LOW;
            end else begin
              w_next_state = ST_DEAD_TO_LO;
              w_next_cnt   = deadTime;
            end
          end
        end
        ST_DEAD_TO_LO: begin
          if (w_pwm_q)                           w_next_state = ST_HIGH;
          else if (r_dead_cnt == DT_WIDTH'(1))   w_next_state = ST_LOW;
          else                                   w_next_cnt   = r_dead_cnt - DT_WIDTH'(1);
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
    if (!is_dead(w_next_state)) w_next_cnt = '0;
  end

  // Outputs register the decode of the next state so they track r_state
  // exactly without adding a cycle of latency.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_IDLE;
      r_dead_cnt   <= '0;
      outHigh      <= 1'b0;
      outLow       <= 1'b0;
      busy         <= 1'b0;
      faultLatched <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_dead_cnt   <= w_next_cnt;
      outHigh      <= (w_next_state == ST_HIGH);
      outLow       <= (w_next_state == ST_LOW);
      busy         <= is_dead(w_next_state);
      faultLatched <= (w_next_state == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: vector table plus hand sequences for reset/fault corners.
module tb_pwm_deadtime;
  import pwm_pkg::*;

  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       resetN;
  logic       enable;
  logic       pwmIn;
  logic [3:0] deadTime;
  logic       fault;
  logic       faultClear;
  logic       outHigh, outLow, faultLatched, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {outHigh, outLow, busy, faultLatched}
  logic [3:0] sb_q[$];

  typedef struct {
    logic       en;
    logic       pwm;
    logic       flt;
    logic       clr;
    logic [3:0] dt;
    int         cyc;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  pwm_deadtime #(.DT_WIDTH(4), .SYNC_STAGES(SYNC)) dut (
    .clock        (clock),
    .resetN       (resetN),
    .enable       (enable),
    .pwmIn        (pwmIn),
    .deadTime     (deadTime),
    .fault        (fault),
    .faultClear   (faultClear),
    .outHigh      (outHigh),
    .outLow       (outLow),
    .faultLatched (faultLatched),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    n_checks++;
    if (outHigh && outLow) begin
      n_fail++;
      $display("FAIL overlap at %0t: outHigh=%b outLow=%b required not both 1", $time, outHigh, outLow);
    end
  end

  function automatic vec_t mk(input logic en, input logic pwm, input logic flt, input logic clr,
                              input logic [3:0] dt, input int cyc, input logic [3:0] exp);
    vec_t v;
    v.en = en; v.pwm = pwm; v.flt = flt; v.clr = clr; v.dt = dt; v.cyc = cyc; v.exp = exp;
    return v;
  endfunction

  task automatic check_pop(input string name);
    logic [3:0] exp;
    logic [3:0] act;
    act = {outHigh, outLow, busy, faultLatched};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got hi/lo/busy/flt=%b", name, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got hi/lo/busy/flt=%b required %b", name, act, exp);
      end
    end
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; pwmIn = 1'b0; deadTime = 4'd0;
    fault = 1'b0; faultClear = 1'b0;

    //        en  pwm flt clr dt  cyc exp(hi lo busy flt)
    vecs.push_back(mk(1, 0, 0, 0, 3, 3, 4'b0100)); // IDLE -> LOW
    vecs.push_back(mk(1, 1, 0, 0, 3, 2, 4'b0100)); // latency: not yet
    vecs.push_back(mk(1, 1, 0, 0, 3, 1, 4'b0010)); // SYNC+1: low falls, dead
    vecs.push_back(mk(1, 1, 0, 0, 3, 2, 4'b0010)); // dead cycles 2,3
    vecs.push_back(mk(1, 1, 0, 0, 3, 1, 4'b1000)); // high after exactly 3
    vecs.push_back(mk(1, 0, 0, 0, 3, 2, 4'b1000));
    vecs.push_back(mk(1, 0, 0, 0, 3, 1, 4'b0010));
    vecs.push_back(mk(1, 0, 0, 0, 3, 2, 4'b0010));
    vecs.push_back(mk(1, 0, 0, 0, 3, 1, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 0, 0, 3, 4'b1000)); // dt=0 direct swap
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 0, 0, 3, 4'b1000));
    vecs.push_back(mk(1, 0, 0, 0, 5, 3, 4'b0010)); // dt=5 to low
    vecs.push_back(mk(1, 0, 0, 0, 5, 4, 4'b0010));
    vecs.push_back(mk(1, 0, 0, 0, 5, 1, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 0, 5, 2, 4'b0100)); // 2-cycle pulse, swallowed
    vecs.push_back(mk(1, 0, 0, 0, 5, 1, 4'b0010));
    vecs.push_back(mk(1, 0, 0, 0, 5, 2, 4'b0100));
    vecs.push_back(mk(1, 0, 0, 0, 5, 6, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 0, 0, 3, 4'b1000)); // HIGH
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 4'b1000)); // fault not yet through sync
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 4'b0001)); // FAULT
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 4'b0001)); // clear ignored while fault
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 4'b0001));
    vecs.push_back(mk(1, 1, 0, 0, 0, 3, 4'b0001)); // latched without clear
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 4'b0000)); // -> IDLE
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 4'b1000)); // IDLE -> HIGH
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 4'b0000)); // disable
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 4'b1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 4'b0100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4'b0000)); // IDLE
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 4'b0001)); // fault from IDLE
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 4'b0001));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'b0100));

    repeat (2) @(negedge clock);
    sb_q.push_back(4'b0000);
    check_pop("reset");
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable     = vecs[i].en;
      pwmIn      = vecs[i].pwm;
      fault      = vecs[i].flt;
      faultClear = vecs[i].clr;
      deadTime   = vecs[i].dt;
      sb_q.push_back(vecs[i].exp);
      repeat (vecs[i].cyc) @(negedge clock);
      check_pop($sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of a maximum-length dead interval.
    pwmIn    = 1'b1;
    deadTime = 4'(DEAD_MAX);
    sb_q.push_back(4'b0010);
    repeat (SYNC + 2) @(negedge clock);
    check_pop("dead_max_busy");
    #2 resetN = 1'b0;
    sb_q.push_back(4'b0000);
    #1 check_pop("async_reset");
    @(negedge clock);
    resetN   = 1'b1;
    enable   = 1'b1;
    pwmIn    = 1'b1;
    deadTime = 4'd0;
    sb_q.push_back(4'b0100);
    @(negedge clock);
    check_pop("post_reset_low");
    sb_q.push_back(4'b1000);
    repeat (SYNC) @(negedge clock);
    check_pop("post_reset_high");

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
